dm_access_unit: RTL and testbench

Memory-stage load/store unit of the pipelined MIPS core. It turns M-stage requests into the external data-memory bus (address, lane-replicated write data, byte enables), then aligns and sign/zero-extends load data into a registered W-stage write-back port. It also detects address exceptions (misaligned or out-of-range accesses) and keeps load/store event counters. Its bus and write-back ports are the core-side end of the data-memory and GRF-trace interface that the system bench drives and checks.

---
 rtl/dm_access_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_dm_access_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// -----------------------------------------------------------------------------
// dm_access_unit
// Memory-stage load/store unit of the pipelined MIPS core.
//
// Converts an M-stage request into the data-memory bus: byte address,
// lane-replicated write data and byte enables. Load data returned on
// m_data_rdata is aligned, sign/zero-extended and registered onto the W-stage
// write-back port. Misaligned or out-of-range accesses raise a one-cycle
// address exception. Retired loads and stores are counted.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   stall, flush        M stage held / M-stage request killed
//   req_*               M-stage request (op, address, store data, ALU result,
//                       GRF write enable, destination register, PC)
//   m_data_*            data-memory bus (addr/wdata/byteen out, rdata in)
//   m_inst_addr         PC of the access
//   w_grf_*, w_inst_addr registered write-back port
//   exc_*               registered address-exception pulse and details
//   load_cnt, store_cnt retired load/store counters (wrap at 2^32)
// -----------------------------------------------------------------------------
module dm_access_unit #(
    parameter logic [31:0] DM_LIMIT = 32'h0000_3FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_alu,
    input  logic        req_we,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_pc,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_badvaddr,
    output logic [31:0] exc_pc,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt
);

    typedef enum logic [3:0] {
        OP_ALU = 4'd0,
        OP_LW  = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LB  = 4'd4,
        OP_LBU = 4'd5,
        OP_SW  = 4'd6,
        OP_SH  = 4'd7,
        OP_SB  = 4'd8
    } mem_op_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    mem_op_e     op_s;
    logic        live_s;
    logic        is_load_s;
    logic        is_store_s;
    logic        misaligned_s;
    logic        out_of_range_s;
    logic        fault_s;
    logic [7:0]  rd_byte_s;
    logic [15:0] rd_half_s;
    logic [31:0] load_data_s;

    logic        w_grf_we_r;
    logic [4:0]  w_grf_addr_r;
    logic [31:0] w_grf_wdata_r;
    logic [31:0] w_inst_addr_r;
    logic        exc_valid_r;
    logic [4:0]  exc_code_r;
    logic [31:0] exc_badvaddr_r;
    logic [31:0] exc_pc_r;
    logic [31:0] load_cnt_r;
    logic [31:0] store_cnt_r;

    // Reset is folded into liveness so the bus drops as soon as reset goes low.
    assign live_s = reset & req_valid & ~stall & ~flush;

    // Opcode decode; unused encodings behave as ALU/pass.
    always_comb begin
        op_s       = OP_ALU;
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        case (req_op)
            4'd1:    begin op_s = OP_LW;  is_load_s  = 1'b1; end
            4'd2:    begin op_s = OP_LH;  is_load_s  = 1'b1; end
            4'd3:    begin op_s = OP_LHU; is_load_s  = 1'b1; end
            4'd4:    begin op_s = OP_LB;  is_load_s  = 1'b1; end
            4'd5:    begin op_s = OP_LBU; is_load_s  = 1'b1; end
            4'd6:    begin op_s = OP_SW;  is_store_s = 1'b1; end
            4'd7:    begin op_s = OP_SH;  is_store_s = 1'b1; end
            4'd8:    begin op_s = OP_SB;  is_store_s = 1'b1; end
            default: begin op_s = OP_ALU; end
        endcase
    end

    // Address-exception detection: alignment by access size, plus range limit.
    always_comb begin
        misaligned_s = 1'b0;
        case (op_s)
            OP_LW, OP_SW:         misaligned_s = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned_s = req_addr[0];
            default:              misaligned_s = 1'b0;
        endcase
        out_of_range_s = (is_load_s | is_store_s) & (req_addr > DM_LIMIT);
        fault_s        = (is_load_s | is_store_s) & (misaligned_s | out_of_range_s);
    end

    // Bus drive: address for any live memory op, lanes only for live stores.
    always_comb begin
        m_data_addr   = 32'h0000_0000;
        m_data_wdata  = 32'h0000_0000;
        m_data_byteen = 4'b0000;
        m_inst_addr   = req_pc;
        if (live_s && (is_load_s || is_store_s)) begin
            m_data_addr = req_addr;
        end else begin
            m_data_addr = 32'h0000_0000;
        end
        if (live_s && is_store_s) begin
            case (op_s)
                OP_SB: begin
                    m_data_wdata  = {4{req_wdata[7:0]}};
                    m_data_byteen = 4'b0001 << req_addr[1:0];
                end
                OP_SH: begin
                    m_data_wdata  = {2{req_wdata[15:0]}};
                    m_data_byteen = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                OP_SW: begin
                    m_data_wdata  = req_wdata;
                    m_data_byteen = 4'b1111;
                end
                default: begin
                    m_data_wdata  = 32'h0000_0000;
                    m_data_byteen = 4'b0000;
                end
            endcase
            // A faulting store keeps its data lanes but must not write memory.
            if (fault_s) begin
                m_data_byteen = 4'b0000;
            end else begin
                m_data_byteen = m_data_byteen;
            end
        end else begin
            m_data_wdata  = 32'h0000_0000;
            m_data_byteen = 4'b0000;
        end
    end

    // Load alignment and extension of the word returned by memory.
    always_comb begin
        rd_byte_s   = 8'h00;
        load_data_s = req_alu;
        case (req_addr[1:0])
            2'd0:    rd_byte_s = m_data_rdata[7:0];
            2'd1:    rd_byte_s = m_data_rdata[15:8];
            2'd2:    rd_byte_s = m_data_rdata[23:16];
            2'd3:    rd_byte_s = m_data_rdata[31:24];
            default: rd_byte_s = 8'h00;
        endcase
        if (req_addr[1]) begin
            rd_half_s = m_data_rdata[31:16];
        end else begin
            rd_half_s = m_data_rdata[15:0];
        end
        case (op_s)
            OP_LW:   load_data_s = m_data_rdata;
            OP_LH:   load_data_s = {{16{rd_half_s[15]}}, rd_half_s};
            OP_LHU:  load_data_s = {16'h0000, rd_half_s};
            OP_LB:   load_data_s = {{24{rd_byte_s[7]}}, rd_byte_s};
            OP_LBU:  load_data_s = {24'h00_0000, rd_byte_s};
            default: load_data_s = req_alu;
        endcase
    end

    // W-stage write-back register; a non-live cycle inserts a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_grf_we_r    <= 1'b0;
            w_grf_addr_r  <= 5'd0;
            w_grf_wdata_r <= 32'h0000_0000;
            w_inst_addr_r <= 32'h0000_0000;
        end else if (live_s) begin
            w_grf_we_r    <= req_we & (req_rd != 5'd0) & ~fault_s & ~is_store_s;
            w_grf_addr_r  <= req_rd;
            w_grf_wdata_r <= load_data_s;
            w_inst_addr_r <= req_pc;
        end else begin
            w_grf_we_r    <= 1'b0;
        end
    end

    // Exception register: one-cycle pulse, details held until the next fault.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exc_valid_r    <= 1'b0;
            exc_code_r     <= 5'd0;
            exc_badvaddr_r <= 32'h0000_0000;
            exc_pc_r       <= 32'h0000_0000;
        end else if (live_s && fault_s) begin
            exc_valid_r    <= 1'b1;
            exc_code_r     <= is_store_s ? EXC_ADES : EXC_ADEL;
            exc_badvaddr_r <= req_addr;
            exc_pc_r       <= req_pc;
        end else begin
            exc_valid_r    <= 1'b0;
        end
    end

    // Retired access counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_cnt_r  <= 32'h0000_0000;
            store_cnt_r <= 32'h0000_0000;
        end else if (live_s && !fault_s) begin
            if (is_load_s) begin
                load_cnt_r <= load_cnt_r + 32'd1;
            end
            if (is_store_s) begin
                store_cnt_r <= store_cnt_r + 32'd1;
            end
        end
    end

    assign w_grf_we     = w_grf_we_r;
    assign w_grf_addr   = w_grf_addr_r;
    assign w_grf_wdata  = w_grf_wdata_r;
    assign w_inst_addr  = w_inst_addr_r;
    assign exc_valid    = exc_valid_r;
    assign exc_code     = exc_code_r;
    assign exc_badvaddr = exc_badvaddr_r;
    assign exc_pc       = exc_pc_r;
    assign load_cnt     = load_cnt_r;
    assign store_cnt    = store_cnt_r;

endmodule

// File: tb/tb_dm_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dm_access_unit
// Directed test-plan steps followed by randomized requests, each cycle checked
// against a behavioural model of the load/store unit.
// -----------------------------------------------------------------------------
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        reset, stall, flush, req_valid, req_we;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_alu, req_pc, m_data_rdata;
    logic [4:0]  req_rd;
    logic [31:0] m_data_addr, m_data_wdata, m_inst_addr;
    logic [3:0]  m_data_byteen;
    logic        w_grf_we, exc_valid;
    logic [4:0]  w_grf_addr, exc_code;
    logic [31:0] w_grf_wdata, w_inst_addr, exc_badvaddr, exc_pc, load_cnt, store_cnt;

    int compared = 0;
    int mismatched = 0;

    // model state (registered outputs)
    logic        e_we, e_exc;
    logic [4:0]  e_waddr, e_code;
    logic [31:0] e_wdata, e_wpc, e_bad, e_epc, e_lcnt, e_scnt;

    // bus values seen in the last step, for directed checks
    logic [31:0] seen_wdata;
    logic [3:0]  seen_byteen;

    dm_access_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_alu(req_alu), .req_we(req_we),
        .req_rd(req_rd), .req_pc(req_pc),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata),
        .m_inst_addr(m_inst_addr),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
        .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr),
        .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_badvaddr(exc_badvaddr), .exc_pc(exc_pc),
        .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request cycle: drive, check the bus, clock, update model, check W/exc/counters.
    task automatic step(input logic rst, input logic v, input logic st, input logic fl,
                        input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] alu, input logic we, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] rdata);
        int  o, k;
        bit  live, ld, sto, mem, mis, flt;
        logic [31:0] x_addr, x_wdata, ext, sel;
        logic [3:0]  x_be;
        reset = rst; req_valid = v; stall = st; flush = fl; req_op = op;
        req_addr = addr; req_wdata = wd; req_alu = alu; req_we = we; req_rd = rd;
        req_pc = pc; m_data_rdata = rdata;
        #2;
        o    = (op > 4'd8) ? 0 : int'(op);
        k    = int'(addr[1:0]);
        live = rst && v && !st && !fl;
        ld   = (o >= 1) && (o <= 5);
        sto  = (o >= 6) && (o <= 8);
        mem  = ld || sto;
        mis  = ((o == 1 || o == 6) && k != 0) || ((o == 2 || o == 3 || o == 7) && (k % 2) != 0);
        flt  = mem && (mis || addr > 32'h0000_3FFF);
        x_addr = (live && mem) ? addr : 32'd0;
        x_wdata = 32'd0;
        x_be    = 4'd0;
        if (live && o == 8) begin x_wdata = 32'h0101_0101 * (wd & 32'hFF);  x_be = 4'(1 << k); end
        if (live && o == 7) begin x_wdata = 32'h0001_0001 * (wd & 32'hFFFF); x_be = (k >= 2) ? 4'b1100 : 4'b0011; end
        if (live && o == 6) begin x_wdata = wd; x_be = 4'b1111; end
        if (flt) x_be = 4'd0;
        chk("bus_addr", m_data_addr, x_addr);
        chk("bus_wdata", m_data_wdata, x_wdata);
        chk("bus_byteen", {28'd0, m_data_byteen}, {28'd0, x_be});
        chk("bus_pc", m_inst_addr, pc);
        seen_wdata = m_data_wdata;
        seen_byteen = m_data_byteen;
        // expected load value
        ext = alu;
        if (o == 1) ext = rdata;
        if (o == 2 || o == 3) begin
            sel = (rdata >> (16 * (k / 2))) & 32'hFFFF;
            ext = (o == 2 && sel >= 32'h8000) ? (sel | 32'hFFFF_0000) : sel;
        end
        if (o == 4 || o == 5) begin
            sel = (rdata >> (8 * k)) & 32'hFF;
            ext = (o == 4 && sel >= 32'h80) ? (sel | 32'hFFFF_FF00) : sel;
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            e_we = 0; e_waddr = 0; e_wdata = 0; e_wpc = 0;
            e_exc = 0; e_code = 0; e_bad = 0; e_epc = 0; e_lcnt = 0; e_scnt = 0;
        end else begin
            e_exc = live && flt;
            if (e_exc) begin e_code = sto ? 5'd5 : 5'd4; e_bad = addr; e_epc = pc; end
            if (live) begin
                e_we = we && rd != 0 && !flt && !sto;
                e_waddr = rd; e_wdata = ext; e_wpc = pc;
            end else e_we = 0;
            if (live && !flt && ld)  e_lcnt = e_lcnt + 1;
            if (live && !flt && sto) e_scnt = e_scnt + 1;
        end
        chk("w_we", {31'd0, w_grf_we}, {31'd0, e_we});
        chk("w_addr", {27'd0, w_grf_addr}, {27'd0, e_waddr});
        chk("w_wdata", w_grf_wdata, e_wdata);
        chk("w_pc", w_inst_addr, e_wpc);
        chk("exc_valid", {31'd0, exc_valid}, {31'd0, e_exc});
        if (e_exc) begin
            chk("exc_code", {27'd0, exc_code}, {27'd0, e_code});
            chk("exc_bad", exc_badvaddr, e_bad);
            chk("exc_pc", exc_pc, e_epc);
        end
        chk("load_cnt", load_cnt, e_lcnt);
        chk("store_cnt", store_cnt, e_scnt);
    endtask

    initial begin
        int nbe;
        logic [31:0] a;
        logic [3:0]  op;
        int sel;
        {e_we, e_exc, e_waddr, e_code, e_wdata, e_wpc, e_bad, e_epc, e_lcnt, e_scnt} = '0;
        @(posedge clk); #1;
        // reset
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h10, 32'h0, 32'h0, 1'b1, 5'd3, 32'h3000, 32'h5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("rst_w_we", {31'd0, w_grf_we}, 32'd0);
        chk("rst_store_cnt", store_cnt, 32'd0);

        // SB 0x1003
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 32'h1003, 32'h1234_5678, 32'h0, 1'b0, 5'd0, 32'h3000, 32'h0);
        chk("tp_sb_byteen", {28'd0, seen_byteen}, {28'd0, 4'b1000});
        chk("tp_sb_wdata", seen_wdata, 32'h7878_7878);
        chk("tp_sb_cnt", store_cnt, 32'd1);

        // LH / LHU to $5
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h2, 32'h0, 32'h0, 1'b1, 5'd5, 32'h3004, 32'h8001_0000);
        chk("tp_lh_we", {31'd0, w_grf_we}, 32'd1);
        chk("tp_lh_addr", {27'd0, w_grf_addr}, 32'd5);
        chk("tp_lh_data", w_grf_wdata, 32'hFFFF_8001);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h2, 32'h0, 32'h0, 1'b1, 5'd5, 32'h3008, 32'h8001_0000);
        chk("tp_lhu_data", w_grf_wdata, 32'h0000_8001);

        // misaligned LW
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h6, 32'h0, 32'h0, 1'b1, 5'd7, 32'h3010, 32'h0);
        chk("tp_lw_exc", {31'd0, exc_valid}, 32'd1);
        chk("tp_lw_code", {27'd0, exc_code}, 32'd4);
        chk("tp_lw_bad", exc_badvaddr, 32'h6);
        chk("tp_lw_pc", exc_pc, 32'h3010);
        chk("tp_lw_we", {31'd0, w_grf_we}, 32'd0);

        // out-of-range SW
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 32'h4000, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd0, 32'h3014, 32'h0);
        chk("tp_sw_oor_be", {28'd0, seen_byteen}, 32'd0);
        chk("tp_sw_oor_code", {27'd0, exc_code}, 32'd5);
        chk("tp_sw_oor_cnt", store_cnt, 32'd1);

        // SW stalled 3 cycles, then released
        nbe = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i < 3), 1'b0, 4'd6, 32'h0100, 32'hCAFE_F00D, 32'h0, 1'b0, 5'd0, 32'h3018, 32'h0);
            if (seen_byteen != 4'd0) nbe++;
        end
        chk("tp_stall_be_cycles", nbe, 32'd1);
        chk("tp_stall_cnt", store_cnt, 32'd2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 32'h0100, 32'hCAFE_F00D, 32'h0, 1'b0, 5'd0, 32'h301C, 32'h0);
        chk("tp_flush_be", {28'd0, seen_byteen}, 32'd0);
        chk("tp_flush_cnt", store_cnt, 32'd2);

        // ALU to $0
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h55, 1'b1, 5'd0, 32'h3020, 32'h0);
        chk("tp_alu_r0_we", {31'd0, w_grf_we}, 32'd0);

        // load then reset
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h8, 32'h0, 32'h0, 1'b1, 5'd9, 32'h3024, 32'h1111_2222);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'hC, 32'h0, 32'h0, 1'b1, 5'd9, 32'h3028, 32'h3333_4444);
        chk("tp_rst_wdata", w_grf_wdata, 32'd0);
        chk("tp_rst_lcnt", load_cnt, 32'd0);
        chk("tp_rst_scnt", store_cnt, 32'd0);
        chk("tp_rst_exc", {31'd0, exc_valid}, 32'd0);

        // randomized requests
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h4000 + $urandom_range(0, 255);
            else if (sel == 1) a = $urandom();
            else if (sel == 2) a = 32'h3FFC + $urandom_range(0, 3);
            else               a = $urandom_range(0, 32'h3FFF);
            op = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                 op, a, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom(), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
